// File: rtl/cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// cla_wide_add_seq
//   Wide add/subtract unit that reuses a single 16-bit carry-lookahead slice
//   over WORDS clock cycles, least-significant slice first. The carry between
//   slices lives in a register. Operands arrive on a valid/ready handshake
//   and the result leaves on a second valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over everything)
//   in_valid   operand request valid
//   in_ready   high only while idle, i.e. able to accept an operation
//   op_sub     0 = a + b, 1 = a - b (sampled on accept)
//   a, b       W-bit operands (sampled on accept)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes the result
//   sum        W-bit result, modulo 2^W
//   cout       final carry-out (for subtract, 1 = no borrow)
//   ovf        two's-complement signed overflow of the W-bit operation
//
// Parameters
//   WORDS      number of 16-bit slices, legal range 2..16; W = 16*WORDS
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla16
//   16-bit two-level carry-lookahead adder: four 4-bit groups, each producing
//   group generate/propagate, with the group carries expanded in one level.
//
// Ports
//   a_i, b_i   16-bit addends
//   cin_i      carry-in
//   sum_o      16-bit sum
//   cout_o     carry-out
// ---------------------------------------------------------------------------
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] bitGen;
  logic [15:0] bitProp;
  logic [15:0] bitCarry;
  logic [3:0]  grpGen;
  logic [3:0]  grpProp;
  logic [4:0]  grpCarry;

  // Per-bit generate and propagate terms.
  assign bitGen  = a_i & b_i;
  assign bitProp = a_i ^ b_i;

  // Group generate/propagate for each 4-bit nibble.
  for (genvar j = 0; j < 4; j++) begin : gGroup
    assign grpGen[j]  = bitGen[4*j+3]
                      | (bitProp[4*j+3] & bitGen[4*j+2])
                      | (bitProp[4*j+3] & bitProp[4*j+2] & bitGen[4*j+1])
                      | (bitProp[4*j+3] & bitProp[4*j+2] & bitProp[4*j+1] & bitGen[4*j]);
    assign grpProp[j] = &bitProp[4*j+3:4*j];
  end

  // Group carries fully expanded from cin so no carry ripples between groups.
  assign grpCarry[0] = cin_i;
  assign grpCarry[1] = grpGen[0] | (grpProp[0] & cin_i);
  assign grpCarry[2] = grpGen[1] | (grpProp[1] & grpGen[0])
                     | (grpProp[1] & grpProp[0] & cin_i);
  assign grpCarry[3] = grpGen[2] | (grpProp[2] & grpGen[1])
                     | (grpProp[2] & grpProp[1] & grpGen[0])
                     | (grpProp[2] & grpProp[1] & grpProp[0] & cin_i);
  assign grpCarry[4] = grpGen[3] | (grpProp[3] & grpGen[2])
                     | (grpProp[3] & grpProp[2] & grpGen[1])
                     | (grpProp[3] & grpProp[2] & grpProp[1] & grpGen[0])
                     | (grpProp[3] & grpProp[2] & grpProp[1] & grpProp[0] & cin_i);

  // Bit carries inside each group, derived directly from that group's carry-in.
  for (genvar j = 0; j < 4; j++) begin : gBitCarry
    assign bitCarry[4*j]   = grpCarry[j];
    assign bitCarry[4*j+1] = bitGen[4*j] | (bitProp[4*j] & grpCarry[j]);
    assign bitCarry[4*j+2] = bitGen[4*j+1] | (bitProp[4*j+1] & bitGen[4*j])
                           | (bitProp[4*j+1] & bitProp[4*j] & grpCarry[j]);
    assign bitCarry[4*j+3] = bitGen[4*j+2] | (bitProp[4*j+2] & bitGen[4*j+1])
                           | (bitProp[4*j+2] & bitProp[4*j+1] & bitGen[4*j])
                           | (bitProp[4*j+2] & bitProp[4*j+1] & bitProp[4*j] & grpCarry[j]);
  end

  assign sum_o  = bitProp ^ bitCarry;
  assign cout_o = grpCarry[4];

endmodule

module cla_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int W    = 16 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q;
  logic [W-1:0]    opA_q;
  logic [W-1:0]    opB_q;
  logic            carry_q;
  logic [IDXW-1:0] sliceIdx_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            outValid_q;

  logic [31:0]     sliceBase;
  logic [15:0]     sliceA;
  logic [15:0]     sliceB;
  logic [15:0]     sliceSum;
  logic            sliceCout;

  // Bit offset of the slice being worked on this cycle.
  assign sliceBase = {{(32-IDXW){1'b0}}, sliceIdx_q} << 4;
  assign sliceA    = opA_q[sliceBase +: 16];
  assign sliceB    = opB_q[sliceBase +: 16];

  cla16 uSlice (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout)
  );

  // Sequencer. Subtraction is folded into the operand register: B is stored
  // inverted and the carry register starts at 1, so every slice is a plain add.
  // Overflow is judged on the stored (possibly inverted) B against the MSB
  // that the final slice produces.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      sliceIdx_q <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q      <= a;
            opB_q      <= op_sub ? ~b : b;
            carry_q    <= op_sub;
            sliceIdx_q <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[sliceBase +: 16] <= sliceSum;
          carry_q                <= sliceCout;
          if (sliceIdx_q == LAST_IDX) begin
            cout_q     <= sliceCout;
            ovf_q      <= (opA_q[W-1] == opB_q[W-1]) & (sliceSum[15] != opA_q[W-1]);
            outValid_q <= 1'b1;
            sliceIdx_q <= '0;
            state_q    <= DONE;
          end else begin
            sliceIdx_q <= sliceIdx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_wide_add_seq
//   Directed, table-driven bench for cla_wide_add_seq with WORDS = 4 (64-bit
//   operands). Expected results are hand-computed constants. Hand-written
//   sequences cover backpressure, input churn during RUN and mid-run reset.
// ---------------------------------------------------------------------------
module tb_cla_wide_add_seq;

  localparam int WORDS   = 4;
  localparam int W       = 16 * WORDS;
  localparam int MAX_WAIT = 40;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int nCompared;
  int nFailed;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
  } vec_t;

  vec_t vecs[10];

  cla_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string what, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", what, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one operation while idle and waits (bounded) for the result.
  // Returns the number of cycles from the accept edge to out_valid.
  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic sub, output int latency);
    checkOutput("in_ready before accept", W'(in_ready), W'(1));
    in_valid = 1'b1;
    a        = opA;
    b        = opB;
    op_sub   = sub;
    stepCycle();
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < MAX_WAIT) begin
      stepCycle();
      latency++;
    end
  endtask

  // Consumes the result and confirms the block is ready again next cycle.
  task automatic drainResult();
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("out_valid after drain", W'(out_valid), W'(0));
    checkOutput("in_ready after drain", W'(in_ready), W'(1));
  endtask

  task automatic checkResult(input string name, input logic [W-1:0] expSum,
                             input logic expCout, input logic expOvf);
    checkOutput({name, " out_valid"}, W'(out_valid), W'(1));
    checkOutput({name, " sum"}, sum, expSum);
    checkOutput({name, " cout"}, W'(cout), W'(expCout));
    checkOutput({name, " ovf"}, W'(ovf), W'(expOvf));
  endtask

  // Main test sequence.
  initial begin
    int lat;
    nCompared = 0;
    nFailed   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    vecs[0] = '{"carry ripple",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   1'b1, 1'b0};
    vecs[1] = '{"cross slice",    64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[2] = '{"sub borrow",     64'h5,                   64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub no borrow",  64'h7,                   64'h5, 1'b1, 64'h2,                   1'b1, 1'b0};
    vecs[4] = '{"add ovf",        64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{"sub ovf",        64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{"zero add",       64'h0,                   64'h0, 1'b0, 64'h0,                   1'b0, 1'b0};
    vecs[7] = '{"zero sub",       64'h0,                   64'h0, 1'b1, 64'h0,                   1'b1, 1'b0};
    vecs[8] = '{"mixed add",      64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[9] = '{"neg add ovf",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'h0,                   1'b1, 1'b1};

    // Reset state.
    stepCycle();
    stepCycle();
    checkOutput("reset in_ready", W'(in_ready), W'(1));
    checkOutput("reset out_valid", W'(out_valid), W'(0));
    checkOutput("reset sum", sum, W'(0));
    checkOutput("reset cout", W'(cout), W'(0));
    checkOutput("reset ovf", W'(ovf), W'(0));
    rst = 1'b0;
    stepCycle();

    // Table-driven vectors, each with a latency check.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      checkOutput({vecs[i].name, " latency"}, W'(lat), W'(WORDS));
      checkResult(vecs[i].name, vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);
      drainResult();
    end

    // Backpressure: result and flags hold while out_ready stays low.
    applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
    checkOutput("bp latency", W'(lat), W'(WORDS));
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkResult("bp hold", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
      checkOutput("bp in_ready", W'(in_ready), W'(0));
    end
    drainResult();

    // Inputs churn during RUN (including out_ready); result must follow the
    // operands captured at accept.
    checkOutput("churn in_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    a        = 64'h1234_5678_9ABC_DEF0;
    b        = 64'h0FED_CBA9_8765_4321;
    op_sub   = 1'b0;
    stepCycle();
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      in_valid  = 1'($urandom_range(0, 1));
      op_sub    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      stepCycle();
      lat++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("churn latency", W'(lat), W'(WORDS));
    checkResult("churn", 64'h2222_2222_2222_2211, 1'b0, 1'b0);
    stepCycle();
    checkResult("churn hold", 64'h2222_2222_2222_2211, 1'b0, 1'b0);
    drainResult();

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1;
    a        = 64'h1111_1111_1111_1111;
    b        = 64'h1111_1111_1111_1111;
    op_sub   = 1'b0;
    stepCycle();
    in_valid = 1'b0;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midrst in_ready", W'(in_ready), W'(1));
    checkOutput("midrst out_valid", W'(out_valid), W'(0));
    checkOutput("midrst sum", sum, W'(0));
    checkOutput("midrst cout", W'(cout), W'(0));
    checkOutput("midrst ovf", W'(ovf), W'(0));

    // Operation after the reset behaves normally.
    applyStimulus(64'h3, 64'h4, 1'b0, lat);
    checkOutput("post-reset latency", W'(lat), W'(WORDS));
    checkResult("post-reset", 64'h7, 1'b0, 1'b0);
    drainResult();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
